// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory types and arbiter state encoding
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Data side always wins; fetch may starve while MEM keeps requesting.
  function automatic arb_state_t arbitrate(input logic dreq, input logic ireq);
    if (dreq)
      return SERVE_D;
    else if (ireq)
      return SERVE_I;
    return IDLE;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - per-grant cycle counter that flags RAM accesses that never complete
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = count_en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (count_en && !expired)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grants the unified RAM port to fetch or data, locked until completion
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout,
  output logic        ramerr
);

  arb_state_t state;
  ramstate_t  rs;
  logic       dreq, ireq, serving, access, err, withdraw;
  logic       wd_clear, wd_count, wd_expired;

  assign rs       = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign ireq     = iREN;
  assign serving  = (state != IDLE);
  assign access   = (rs == ACCESS);
  assign err      = (rs == ERROR);
  assign withdraw = ((state == SERVE_D) && !dreq) || ((state == SERVE_I) && !ireq);

  // Counter restarts whenever the current grant ends, so each new grant starts from zero.
  assign wd_clear = !serving || access || err || withdraw;
  assign wd_count = serving && !access;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      timeout <= 1'b0;
      ramerr  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= arbitrate(dreq, ireq);
        default: begin
          if (err) begin
            ramerr <= 1'b1;
            state  <= IDLE;
          end else if (access) begin
            state <= arbitrate(dreq, ireq);
          end else if (withdraw) begin
            state <= IDLE;
          end else if (wd_expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      SERVE_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (access) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      SERVE_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (access) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .timeout(timeout), .ramerr(ramerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Completions are scored at the falling edge against the queued expectations.
  always @(negedge CLK) begin
    if (!RST) begin
      if (!iwait) begin
        if (iq.size() == 0) begin
          check("i_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = iq.pop_front();
          check("i_addr", ramaddr, e.addr);
          check("iload", iload, e.data);
        end
      end
      if (!dwait) begin
        if (dq.size() == 0) begin
          check("d_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          check("d_addr", ramaddr, e.addr);
          check("dload", dload, e.data);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    cyc(); cyc();
    #3;
    check("rst_iwait", iwait, 1);    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);    check("rst_dload", dload, 0);
    check("rst_ramREN", ramREN, 0);  check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0); check("rst_ramstore", ramstore, 0);
    check("rst_timeout", timeout, 0); check("rst_ramerr", ramerr, 0);
    RST = 1'b0;

    // instruction only, ACCESS on the first grant cycle
    cyc();
    iREN = 1; iaddr = 32'h40;
    iq.push_back('{32'h40, 32'hDEADBEEF});
    cyc();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #3;
    check("t1_ramREN", ramREN, 1);
    check("t1_iwait", iwait, 0);
    #3;
    iREN = 0; ramstate = FREE;
    cyc(); #3;
    check("t1_idle_ren", ramREN, 0);

    // simultaneous write and fetch: data first, fetch back-to-back
    cyc();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
    dq.push_back('{32'h80, 32'h55});
    iq.push_back('{32'h44, 32'hCAFE0001});
    cyc();
    ramstate = ACCESS; ramload = 32'h55;
    #3;
    check("t2_ramWEN", ramWEN, 1);   check("t2_ramREN_d", ramREN, 0);
    check("t2_ramaddr_d", ramaddr, 32'h80); check("t2_ramstore", ramstore, 32'h1234);
    check("t2_iwait_held", iwait, 1);
    #3;
    dWEN = 0;
    cyc();
    ramload = 32'hCAFE0001;
    #3;
    check("t2_ramREN_i", ramREN, 1); check("t2_ramWEN_i", ramWEN, 0);
    check("t2_ramaddr_i", ramaddr, 32'h44); check("t2_ramstore_i", ramstore, 0);
    #3;
    iREN = 0; ramstate = FREE;
    cyc();

    // no preemption of an open fetch grant
    iREN = 1; iaddr = 32'h48; ramstate = BUSY;
    iq.push_back('{32'h48, 32'h11111111});
    cyc();
    dREN = 1; daddr = 32'h90;
    dq.push_back('{32'h90, 32'h22222222});
    for (int k = 0; k < 3; k++) begin
      #3;
      check("t3_hold_addr", ramaddr, 32'h48);
      check("t3_dwait", dwait, 1);
      check("t3_iwait", iwait, 1);
      cyc();
    end
    ramstate = ACCESS; ramload = 32'h11111111;
    #3;
    check("t3_done_addr", ramaddr, 32'h48);
    #3;
    iREN = 0;
    cyc();
    ramload = 32'h22222222;
    #3;
    check("t3_d_ren", ramREN, 1);
    #3;
    dREN = 0; ramstate = FREE;
    cyc();

    // watchdog with TIMEOUT=8
    dREN = 1; daddr = 32'hA0; ramstate = BUSY;
    cyc();
    for (int k = 0; k < 8; k++) begin
      #3;
      check("t4_grant_open", ramREN, 1);
      check("t4_no_timeout", timeout, 0);
      check("t4_dwait", dwait, 1);
      cyc();
    end
    #3;
    check("t4_timeout", timeout, 1);
    check("t4_idle", ramREN, 0);
    check("t4_dwait_after", dwait, 1);
    check("t4_iwait_after", iwait, 1);
    #3;
    dREN = 0; ramstate = FREE;
    cyc(); cyc(); #3;
    check("t4_sticky", timeout, 1);

    // error during SERVE_D, re-grant, then reset mid-grant
    #3;
    dREN = 1; daddr = 32'hB0;
    cyc();
    ramstate = ERROR;
    #3;
    check("t5_dwait_err", dwait, 1);
    check("t5_ramerr_pre", ramerr, 0);
    #3;
    cyc();
    ramstate = FREE;
    #3;
    check("t5_ramerr", ramerr, 1);
    check("t5_idle", ramREN, 0);
    check("t5_dwait", dwait, 1);
    cyc(); #3;
    check("t5_regrant", ramREN, 1);
    check("t5_regrant_addr", ramaddr, 32'hB0);
    RST = 1'b1;
    #1;
    check("t5_rst_ren", ramREN, 0);   check("t5_rst_wen", ramWEN, 0);
    check("t5_rst_timeout", timeout, 0); check("t5_rst_ramerr", ramerr, 0);
    check("t5_rst_dwait", dwait, 1);
    #2;
    dREN = 0;
    RST = 1'b0;
    cyc(); cyc();
    check("iq_left", iq.size(), 0);
    check("dq_left", dq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
